// File: rtl/rom_dl_pkg.sv
// Shared types and width helpers for the ROM download sequencer.
package rom_dl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_LOAD,
        ST_CHECK,
        ST_HOLD,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam int IO_AW = 25;
    localparam int CNT_W = 25;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int log2_of(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_stretch.sv
// Loadable down-counter; done is high once the count has drained to zero.
module reset_stretch
    import rom_dl_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024
) (
    input  logic clk_sys,
    input  logic res_n,
    input  logic load,
    output logic done
);

    localparam int CW = width_of(HOLD_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/rom_download_ctrl.sv
// ROM download decoder, image validator and core reset sequencer.
module rom_download_ctrl
    import rom_dl_pkg::*;
#(
    parameter int          NREG        = 4,
    parameter int          AW          = 14,
    parameter logic [7:0]  INDEX       = 8'h00,
    parameter int          MIN_BYTES   = 16384,
    parameter int          HOLD_CYCLES = 1024
) (
    input  logic             clk_sys,
    input  logic             res_n,
    input  logic             ioctl_downl,
    input  logic [7:0]       ioctl_index,
    input  logic             ioctl_wr,
    input  logic [24:0]      ioctl_addr,
    input  logic [7:0]       ioctl_dout,
    input  logic             user_reset,
    output logic             core_reset,
    output logic             rom_ready,
    output logic             load_error,
    output logic [NREG-1:0]  dn_wr,
    output logic [AW-1:0]    dn_addr,
    output logic [7:0]       dn_data
);

    localparam int RW   = log2_of(NREG);
    localparam int RSW  = width_of(NREG);
    localparam int SPAN = AW + RW;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BYTES);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              seen_nz;

    logic              sel;
    logic              in_range;
    logic [RSW-1:0]    reg_idx;
    logic [NREG-1:0]   reg_hot;
    logic              accept;
    logic              image_ok;
    logic              hold_load;
    logic              hold_done;
    logic [CNT_W-1:0]  count_inc;

    assign sel      = ioctl_downl && (ioctl_index == INDEX);
    assign in_range = ((ioctl_addr >> SPAN) == '0);
    assign reg_idx  = RSW'(ioctl_addr >> AW);
    assign reg_hot  = NREG'(1) << reg_idx;
    assign accept   = (state == ST_LOAD) && ioctl_wr && in_range;
    assign image_ok = (count >= MIN_CNT) && seen_nz;

    assign count_inc = (&count) ? count : count + 1'b1;

    // Reload the stretcher on every HOLD entry and on every user_reset cycle
    // while holding; a new download outranks both.
    assign hold_load = !sel && (
        ((state == ST_CHECK) && image_ok) ||
        (((state == ST_RUN) || (state == ST_HOLD)) && user_reset)
    );

    reset_stretch #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_stretch (
        .clk_sys (clk_sys),
        .res_n   (res_n),
        .load    (hold_load),
        .done    (hold_done)
    );

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state      <= ST_BOOT;
            count      <= '0;
            seen_nz    <= 1'b0;
            core_reset <= 1'b1;
            rom_ready  <= 1'b0;
            load_error <= 1'b0;
            dn_wr      <= '0;
            dn_addr    <= '0;
            dn_data    <= '0;
        end else begin
            dn_wr      <= '0;
            core_reset <= 1'b1;

            if (accept) begin
                dn_wr   <= reg_hot;
                dn_addr <= ioctl_addr[AW-1:0];
                dn_data <= ioctl_dout;
                count   <= count_inc;
                if (ioctl_dout != 8'h00) begin
                    seen_nz <= 1'b1;
                end
            end

            unique case (state)
                ST_BOOT, ST_FAIL: begin
                    if (sel) begin
                        state     <= ST_LOAD;
                        count     <= '0;
                        seen_nz   <= 1'b0;
                        rom_ready <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!sel) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (image_ok) begin
                        rom_ready  <= 1'b1;
                        load_error <= 1'b0;
                        state      <= ST_HOLD;
                    end else begin
                        rom_ready  <= 1'b0;
                        load_error <= 1'b1;
                        state      <= ST_FAIL;
                    end
                end
                ST_HOLD: begin
                    if (sel) begin
                        state     <= ST_LOAD;
                        count     <= '0;
                        seen_nz   <= 1'b0;
                        rom_ready <= 1'b0;
                    end else if (!user_reset && hold_done) begin
                        state      <= ST_RUN;
                        core_reset <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (sel) begin
                        state     <= ST_LOAD;
                        count     <= '0;
                        seen_nz   <= 1'b0;
                        rom_ready <= 1'b0;
                    end else if (user_reset) begin
                        state <= ST_HOLD;
                    end else begin
                        core_reset <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed bench for rom_download_ctrl with a strobe scoreboard.
module tb_rom_download_ctrl;

    logic        clk_sys = 1'b0;
    logic        res_n = 1'b0;
    logic        ioctl_downl = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        user_reset = 1'b0;
    logic        core_reset;
    logic        rom_ready;
    logic        load_error;
    logic [3:0]  dn_wr;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;

    typedef struct {
        logic [3:0]  wr;
        logic [13:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    rom_download_ctrl dut (
        .clk_sys     (clk_sys),
        .res_n       (res_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .user_reset  (user_reset),
        .core_reset  (core_reset),
        .rom_ready   (rom_ready),
        .load_error  (load_error),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (res_n && dn_wr != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {28'h0, dn_wr}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dn_wr", {28'h0, dn_wr}, {28'h0, e.wr});
                chk("dn_addr", {18'h0, dn_addr}, {18'h0, e.addr});
                chk("dn_data", {24'h0, dn_data}, {24'h0, e.data});
                chk("strobe_latency", cyc, e.cyc + 1);
            end
        end
    end

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d,
                           input bit acc, input bit drop_sel);
        logic [1:0] r;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (drop_sel) ioctl_downl = 1'b0;
        r = a[15:14];
        if (acc && a[24:16] == 9'h0) begin
            exp_t e;
            e.wr   = 4'b0001 << r;
            e.addr = a[13:0];
            e.data = d;
            e.cyc  = cyc;
            sb.push_back(e);
        end
        @(negedge clk_sys);
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (core_reset && n < 4000) begin
            @(negedge clk_sys);
            n++;
        end
    endtask

    initial begin
        int n;

        repeat (3) @(negedge clk_sys);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_rom_ready", rom_ready, 0);
        chk("rst_load_error", load_error, 0);
        chk("rst_dn_wr", dn_wr, 0);
        chk("rst_dn_addr", dn_addr, 0);
        chk("rst_dn_data", dn_data, 0);
        res_n = 1'b1;
        repeat (50) @(negedge clk_sys);
        chk("idle_core_reset", core_reset, 1);
        chk("idle_rom_ready", rom_ready, 0);

        // short download with region decode and an out-of-range write
        ioctl_downl = 1'b1;
        ioctl_index = 8'h00;
        repeat (2) @(negedge clk_sys);
        wr_byte(25'h0C123, 8'hA5, 1, 0);
        wr_byte(25'h10000, 8'h77, 1, 0);
        ioctl_wr = 1'b0;
        chk("count_after_oor", dut.count, 1);
        for (int i = 1; i < 100; i++) wr_byte(25'(i), 8'h11, 1, 0);
        ioctl_wr = 1'b0;
        ioctl_downl = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("short_load_error", load_error, 1);
        chk("short_rom_ready", rom_ready, 0);
        chk("short_core_reset", core_reset, 1);
        user_reset = 1'b1;
        repeat (10) @(negedge clk_sys);
        user_reset = 1'b0;
        repeat (20) @(negedge clk_sys);
        chk("fail_ignores_user_reset", core_reset, 1);
        chk("fail_keeps_error", load_error, 1);

        // full valid image; last write coincides with sel falling
        ioctl_downl = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("load_keeps_error", load_error, 1);
        for (int i = 0; i < 16384; i++)
            wr_byte(25'(i), 8'((i % 255) + 1), 1, i == 16383);
        ioctl_wr = 1'b0;
        n = 0;
        while (!rom_ready && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
        chk("full_rom_ready", rom_ready, 1);
        chk("full_load_error", load_error, 0);
        chk("full_check_latency", n, 1);
        wait_release(n);
        chk("hold_length", n, 1024);
        chk("run_core_reset", core_reset, 0);

        // user reset pulse of 5 cycles
        repeat (5) @(negedge clk_sys);
        user_reset = 1'b1;
        @(negedge clk_sys);
        chk("ur_core_reset_rise", core_reset, 1);
        repeat (4) @(negedge clk_sys);
        user_reset = 1'b0;
        wait_release(n);
        chk("ur_hold_length", n, 1024);
        chk("ur_rom_ready", rom_ready, 1);

        // foreign index download while running
        ioctl_downl = 1'b1;
        ioctl_index = 8'h01;
        for (int i = 0; i < 10; i++) wr_byte(25'(i), 8'hFF, 0, 0);
        ioctl_wr = 1'b0;
        chk("foreign_core_reset", core_reset, 0);
        chk("foreign_rom_ready", rom_ready, 1);
        ioctl_downl = 1'b0;
        ioctl_index = 8'h00;
        repeat (3) @(negedge clk_sys);
        chk("foreign_after", core_reset, 0);

        // download interrupted by res_n, then resumed
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        chk("sel_core_reset_rise", core_reset, 1);
        chk("sel_rom_ready_clear", rom_ready, 0);
        for (int i = 0; i < 8000; i++) wr_byte(25'(i), 8'h5A, 1, 0);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        res_n = 1'b0;
        @(negedge clk_sys);
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_count", dut.count, 0);
        chk("midrst_dn_wr", dn_wr, 0);
        res_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 8000; i < 16384; i++)
            wr_byte(25'(i), 8'h5A, 1, i == 16383);
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("partial_load_error", load_error, 1);
        chk("partial_rom_ready", rom_ready, 0);
        chk("partial_core_reset", core_reset, 1);

        // all-zero image of full length
        ioctl_downl = 1'b1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 16384; i++)
            wr_byte(25'(i), 8'h00, 1, i == 16383);
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("zero_load_error", load_error, 1);
        chk("zero_rom_ready", rom_ready, 0);
        chk("zero_count", dut.count, 16384);
        repeat (20) @(negedge clk_sys);
        chk("zero_core_reset", core_reset, 1);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
